// File: rtl/display_ram_writer_if.sv
// display_ram_writer_if: command, RAM write/read port and response signals of the board display RAM writer.
interface display_ram_writer_if #(
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_pos;
    logic              cmd_color;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [1:0]        ram_rd_data;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [1:0]        ram_wr_data;
    logic              resp_valid;
    logic              resp_ok;
    logic              busy;
    modport master (
        output cmd_valid, cmd_op, cmd_pos, cmd_color, ram_rd_data,
        input  cmd_ready, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data, resp_valid, resp_ok, busy
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_pos, cmd_color, ram_rd_data,
        output cmd_ready, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data, resp_valid, resp_ok, busy
    );
endinterface

// File: rtl/display_ram_writer.sv
// display_ram_writer: turns clear/fill/place/remove commands into display RAM writes with a response pulse.
`ifndef SIDE_RED
`define SIDE_RED 1'b1
`endif
module display_ram_writer #(
    parameter int ADDR_W = 6
) (
    input logic clk,
    input logic rst,
    display_ram_writer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, SWEEP} state_t;
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_PLACE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b11;
    localparam logic [ADDR_W-1:0] LAST = '1;
    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic              color_q, color_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        wr_data_q, wr_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_ok_q, resp_ok_d;
    logic              accept, ok;
    logic [1:0]        code_in, code_q;
    assign bus.cmd_ready   = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.ram_rd_addr = pos_q;
    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_wr_data = wr_data_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_ok     = resp_ok_q;
    assign accept  = bus.cmd_valid && state_q == IDLE;
    assign code_in = (bus.cmd_color == `SIDE_RED) ? 2'b10 : 2'b01;
    assign code_q  = (color_q == `SIDE_RED) ? 2'b10 : 2'b01;
    // 11 is treated as occupied, so only a truly empty cell accepts a stone
    assign ok      = (op_q == OP_PLACE) ? bus.ram_rd_data == 2'b00 : bus.ram_rd_data != 2'b00;
    assign cnt_nx  = cnt_q + 1'b1;
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pos_d        = pos_q;
        color_d      = color_q;
        cnt_d        = cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = 2'b00;
        resp_valid_d = 1'b0;
        resp_ok_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = bus.cmd_op;
                    pos_d   = bus.cmd_pos;
                    color_d = bus.cmd_color;
                    if (bus.cmd_op == OP_CLEAR || bus.cmd_op == OP_FILL) begin
                        state_d   = SWEEP;
                        cnt_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = (bus.cmd_op == OP_FILL) ? code_in : 2'b00;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: state_d = CHECK;
            CHECK: begin
                state_d      = WRITE;
                wr_en_d      = ok;
                wr_addr_d    = pos_q;
                wr_data_d    = (ok && op_q == OP_PLACE) ? code_q : 2'b00;
                resp_valid_d = 1'b1;
                resp_ok_d    = ok;
            end
            WRITE: state_d = IDLE;
            SWEEP: begin
                // outputs are registered, so the write for cnt_nx is staged while cnt_q is on the bus
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d        = cnt_nx;
                    wr_en_d      = 1'b1;
                    wr_addr_d    = cnt_nx;
                    wr_data_d    = wr_data_q;
                    resp_valid_d = cnt_nx == LAST;
                    resp_ok_d    = cnt_nx == LAST;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 2'b00;
            pos_q        <= '0;
            color_q      <= 1'b0;
            cnt_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pos_q        <= pos_d;
            color_q      <= color_d;
            cnt_q        <= cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
        end
    end
endmodule
